dmem_responder: RTL

Memory-side responder for cpu_top's data load/store port: the CPU acts as initiator and this block acts as the responding end.
- Accepts one request at a time through a valid/ready handshake.
- Models a configurable access latency.
- Performs byte-enabled word writes and word reads on an internal array.
- Returns a response that is held until the CPU accepts it.

It sits beside cpu_top in bring-up and system benches, and can later be replaced by a real memory subsystem.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state and captured request.
package dmem_pkg;

   localparam int WORD_BYTES   = 4;
   localparam int REQ_ADDR_MAX = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Address is held zero-extended so any ADDR_W up to 64 fits one struct layout.
   typedef struct packed {
      logic                    we;
      logic [REQ_ADDR_MAX-1:0] addr;
      logic [31:0]             wdata;
      logic [WORD_BYTES-1:0]   be;
   } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled synchronous RAM, one array per byte lane, registered read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (en) begin
            if (we && be[gi]) begin
               lane[idx] <= wdata[8*gi +: 8];
            end
            if (!we) begin
               rdata[8*gi +: 8] <= lane[idx];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, fixed
// access latency, byte-enabled stores, response held until the CPU accepts it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dmem_state_t      state;
   logic [CNT_W-1:0] cnt;
   dmem_req_t        req_q;
   dmem_req_t        acc;
   logic             accept;
   logic             go_resp;
   logic             in_range;
   logic             load_ok;
   logic [31:0]      ram_rdata;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;

   // With LATENCY==1 the array is accessed on the accepting edge, so the
   // live request fields are used instead of the (not yet loaded) registers.
   always_comb begin
      acc = req_q;
      if (state == IDLE) begin
         acc.we    = req_we;
         acc.addr  = REQ_ADDR_MAX'(req_addr);
         acc.wdata = req_wdata;
         acc.be    = req_be;
      end
   end

   assign go_resp  = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0));
   assign in_range = ((acc.addr >> (IDX_W + 2)) == '0);

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk  (clk),
      .en   (go_resp && in_range),
      .we   (acc.we),
      .be   (acc.be),
      .idx  (acc.addr[IDX_W+1:2]),
      .wdata(acc.wdata),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         req_q    <= '0;
         resp_err <= 1'b0;
         load_ok  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_q <= acc;
                  cnt   <= CNT_LOAD;
                  state <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (go_resp) begin
            resp_err <= ~in_range;
            load_ok  <= in_range & ~acc.we;
         end else if ((state == RESP) && resp_ready) begin
            resp_err <= 1'b0;
            load_ok  <= 1'b0;
         end
      end
   end

   // The RAM read register holds through RESP; gating it keeps stores, errors
   // and reset returning zero.
   assign resp_rdata = load_ok ? ram_rdata : 32'h0;

endmodule
